// File: rtl/ex_muldiv_seq_if.sv
// Bundle between the EX stage and the iterative mul/div sequencer.
// The master is the pipeline side, which issues the op and consumes the result.
// The slave is the sequencer.
interface ex_muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            ID_EX_muldiv;
    logic [2:0]      ID_EX_mdop;
    logic [4:0]      ID_EX_rd;
    logic [XLEN-1:0] EX_rs1_data;
    logic [XLEN-1:0] EX_rs2_data;
    logic            MD_kill;
    logic            MD_stall;
    logic            MD_done;
    logic [XLEN-1:0] MD_result;
    logic [4:0]      MD_rd;

    modport master (
        output ID_EX_muldiv, ID_EX_mdop, ID_EX_rd, EX_rs1_data, EX_rs2_data, MD_kill,
        input  MD_stall, MD_done, MD_result, MD_rd
    );

    modport slave (
        input  ID_EX_muldiv, ID_EX_mdop, ID_EX_rd, EX_rs1_data, EX_rs2_data, MD_kill,
        output MD_stall, MD_done, MD_result, MD_rd
    );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Iterative M-extension unit that sits beside the EX-stage ALU.
// Multiply uses shift-add and divide uses the restoring method, both at one bit per cycle.
// Every op has a fixed latency of XLEN+1 cycles from start to done.
// The datapath is unsigned. Sign is stripped when the operands are latched and reapplied
// when the result is captured.
module ex_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    ex_muldiv_seq_if.slave md
);
    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] MD_OP_MUL   = 3'd0;
    localparam logic [2:0] MD_OP_MULHU = 3'd1;
    localparam logic [2:0] MD_OP_DIV   = 3'd2;
    localparam logic [2:0] MD_OP_DIVU  = 3'd3;
    localparam logic [2:0] MD_OP_REM   = 3'd4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      op_q;
    logic [4:0]      rd_q;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] a_q;      // multiplier (shifts right) or dividend/quotient (shifts left)
    logic [XLEN-1:0] b_q;      // multiplicand or divisor
    logic [XLEN-1:0] hi_q;     // product high half or partial remainder
    logic            neg_q;    // negate the selected result at capture
    logic [XLEN-1:0] res_q;
    logic [4:0]      rd_out_q;

    logic            start;
    logic [2:0]      op_in;
    logic            sgn_in, s1, s2, neg_in;
    logic [XLEN-1:0] abs1, abs2;
    logic [XLEN:0]   mul_sum, div_sh, div_diff;
    logic [XLEN-1:0] a_nxt, hi_nxt, raw_res, fix_res;
    logic            is_div;

    assign start = (state == IDLE) && md.ID_EX_muldiv && !md.MD_kill;

    assign md.MD_stall  = start || (state == BUSY);
    assign md.MD_done   = (state == DONE);
    assign md.MD_result = res_q;
    assign md.MD_rd     = rd_out_q;

    // Decode the incoming op and form the operand magnitudes and the sign to reapply.
    // Codes 6 and 7 decode as MUL.
    // A signed divide by zero keeps the all-ones quotient, so it must not be negated.
    always_comb begin
        op_in  = (md.ID_EX_mdop > 3'd5) ? MD_OP_MUL : md.ID_EX_mdop;
        sgn_in = (op_in == MD_OP_DIV) || (op_in == MD_OP_REM);
        s1     = sgn_in && md.EX_rs1_data[XLEN-1];
        s2     = sgn_in && md.EX_rs2_data[XLEN-1];
        abs1   = s1 ? (~md.EX_rs1_data + 1'b1) : md.EX_rs1_data;
        abs2   = s2 ? (~md.EX_rs2_data + 1'b1) : md.EX_rs2_data;
        neg_in = 1'b0;
        if (op_in == MD_OP_DIV)
            neg_in = (s1 ^ s2) && (md.EX_rs2_data != '0);
        else if (op_in == MD_OP_REM)
            neg_in = s1;
    end

    // One iteration of the datapath, plus the sign-fixed result of that iteration.
    // The fixed result is captured on the last BUSY cycle.
    always_comb begin
        is_div   = (op_q >= MD_OP_DIV);
        mul_sum  = {1'b0, hi_q} + {1'b0, (a_q[0] ? b_q : '0)};
        div_sh   = {hi_q, a_q[XLEN-1]};
        div_diff = div_sh - {1'b0, b_q};
        if (is_div) begin
            // A set borrow bit means the trial subtract failed, so the shifted value is kept.
            hi_nxt = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
            a_nxt  = {a_q[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            hi_nxt = mul_sum[XLEN:1];
            a_nxt  = {mul_sum[0], a_q[XLEN-1:1]};
        end
        case (op_q)
            MD_OP_MUL, MD_OP_DIV, MD_OP_DIVU: raw_res = a_nxt;
            default:                          raw_res = hi_nxt;
        endcase
        fix_res = neg_q ? (~raw_res + 1'b1) : raw_res;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state. A kill is honoured in BUSY and ignored in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (md.MD_kill) state_nxt = IDLE;
                     else if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch operands at start, iterate while BUSY, and capture the result on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            rd_q     <= '0;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            neg_q    <= 1'b0;
            res_q    <= '0;
            rd_out_q <= '0;
        end else if (start) begin
            op_q  <= op_in;
            rd_q  <= md.ID_EX_rd;
            cnt   <= CW'(XLEN - 1);
            a_q   <= abs1;
            b_q   <= abs2;
            hi_q  <= '0;
            neg_q <= neg_in;
        end else if (state == BUSY) begin
            a_q  <= a_nxt;
            hi_q <= hi_nxt;
            if (cnt != '0)
                cnt <= cnt - 1'b1;
            else if (!md.MD_kill) begin
                res_q    <= fix_res;
                rd_out_q <= rd_q;
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed test for ex_muldiv_seq. Expected values are computed by hand.
module tb_ex_muldiv_seq;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    ex_muldiv_seq_if #(.XLEN(XLEN)) mif ();

    ex_muldiv_seq #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .md  (mif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // The start is driven in cycle 0, which is the cycle whose rising edge samples it.
    // The task then checks combinational stall, latency, stall while busy, and the result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int  n;
        bit  stall_ok;
        @(negedge clk);
        mif.ID_EX_muldiv = 1'b1;
        mif.ID_EX_mdop   = op;
        mif.ID_EX_rd     = rd;
        mif.EX_rs1_data  = a;
        mif.EX_rs2_data  = b;
        #1 check({tag, "_stall_c0"}, {31'b0, mif.MD_stall}, 32'd1);
        @(negedge clk);
        mif.ID_EX_muldiv = 1'b0;
        n = 1;
        stall_ok = 1'b1;
        while (!mif.MD_done && n < 60) begin
            if (!mif.MD_stall) stall_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 32'd33);
        check({tag, "_stall_busy"}, {31'b0, stall_ok}, 32'd1);
        check({tag, "_stall_done"}, {31'b0, mif.MD_stall}, 32'd0);
        check({tag, "_result"}, mif.MD_result, exp);
        check({tag, "_rd"}, {27'b0, mif.MD_rd}, {27'b0, rd});
    endtask

    initial begin
        mif.ID_EX_muldiv = 1'b0;
        mif.ID_EX_mdop   = 3'd0;
        mif.ID_EX_rd     = 5'd0;
        mif.EX_rs1_data  = '0;
        mif.EX_rs2_data  = '0;
        mif.MD_kill      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_done",   {31'b0, mif.MD_done},  32'd0);
        check("rst_stall",  {31'b0, mif.MD_stall}, 32'd0);
        check("rst_result", mif.MD_result,         32'd0);
        check("rst_rd",     {27'b0, mif.MD_rd},    32'd0);
        rst = 1'b0;

        run_op("mul_7x6",  3'd0, 32'd7,        32'd6,        5'd1, 32'd42);
        @(negedge clk);
        check("done_pulse_one_cycle", {31'b0, mif.MD_done}, 32'd0);
        check("result_held", mif.MD_result, 32'd42);
        run_op("mulhu_ff", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE);
        run_op("mul_ff",   3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'h00000001);
        run_op("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2,        5'd4, 32'hFFFFFFFD);
        run_op("rem_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2,        5'd5, 32'hFFFFFFFF);
        run_op("divu_100_7", 3'd3, 32'd100,    32'd7,        5'd6, 32'd14);
        run_op("remu_100_7", 3'd5, 32'd100,    32'd7,        5'd7, 32'd2);
        run_op("divu_by0", 3'd3, 32'h1234,     32'd0,        5'd8, 32'hFFFFFFFF);
        run_op("remu_by0", 3'd5, 32'h1234,     32'd0,        5'd9, 32'h1234);
        run_op("div_ovf",  3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000);
        run_op("rem_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0);
        run_op("div_neg_by0", 3'd2, 32'hFFFFFFFB, 32'd0,     5'd12, 32'hFFFFFFFF);
        run_op("rem_neg_by0", 3'd4, 32'hFFFFFFFB, 32'd0,     5'd13, 32'hFFFFFFFB);
        run_op("op7_as_mul", 3'd7, 32'd3,      32'd5,        5'd14, 32'd15);

        // A kill in cycle 10 leaves MD_stall low from cycle 11, with no done and the old result kept.
        begin
            bit seen_done;
            @(negedge clk);
            mif.ID_EX_muldiv = 1'b1;
            mif.ID_EX_mdop   = 3'd0;
            mif.ID_EX_rd     = 5'd20;
            mif.EX_rs1_data  = 32'd9;
            mif.EX_rs2_data  = 32'd9;
            @(negedge clk);
            mif.ID_EX_muldiv = 1'b0;
            repeat (9) @(negedge clk);
            mif.MD_kill = 1'b1;
            @(negedge clk);
            mif.MD_kill = 1'b0;
            check("kill_stall", {31'b0, mif.MD_stall}, 32'd0);
            seen_done = 1'b0;
            repeat (40) begin
                if (mif.MD_done) seen_done = 1'b1;
                @(negedge clk);
            end
            check("kill_no_done", {31'b0, seen_done}, 32'd0);
            check("kill_result_kept", mif.MD_result, 32'd15);
            check("kill_rd_kept", {27'b0, mif.MD_rd}, 32'd14);
        end
        run_op("after_kill", 3'd3, 32'd81, 32'd9, 5'd21, 32'd9);

        // A reset in cycle 5 of a DIV gives IDLE with zeroed outputs in the next cycle.
        @(negedge clk);
        mif.ID_EX_muldiv = 1'b1;
        mif.ID_EX_mdop   = 3'd2;
        mif.ID_EX_rd     = 5'd22;
        mif.EX_rs1_data  = 32'd50;
        mif.EX_rs2_data  = 32'd5;
        @(negedge clk);
        mif.ID_EX_muldiv = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_done",   {31'b0, mif.MD_done},  32'd0);
        check("rstmid_stall",  {31'b0, mif.MD_stall}, 32'd0);
        check("rstmid_result", mif.MD_result,         32'd0);
        check("rstmid_rd",     {27'b0, mif.MD_rd},    32'd0);

        // Back-to-back starts, each beginning in the cycle after the previous done.
        run_op("b2b_0", 3'd2, 32'd50,        32'd5,  5'd23, 32'd10);
        run_op("b2b_1", 3'd4, 32'd50,        32'd7,  5'd24, 32'd1);
        run_op("b2b_2", 3'd1, 32'h00010000,  32'h00010000, 5'd25, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
